// File: rtl/csr_rmw_unit.sv
// ---------------------------------------------------------------------------
// csr_rmw_unit
//
// Pipelined CSR read-modify-write unit placed between EX and WB. It holds
// NUM_CSR control/status registers and executes the six Zicsr operations:
// RW/RS/RC take their operand from rs1, and RWI/RSI/RCI take it from the
// zero-extended 5-bit immediate. For each request the unit returns the CSR
// value as it was before the operation.
//
// Pipeline:
//   S1 (_p1): captures the accepted request, the decoded CSR index, the
//             implemented flag and the selected operand.
//   S2      : reads the CSR, computes the new value, writes it back and
//             registers the response.
// A request accepted at edge t shows up as a response at edge t+1, so the
// consumer sees it two cycles after it was presented. With resp_ready held
// high the unit sustains one operation per cycle. Operations are applied in
// order in S2, so back-to-back operations to the same CSR see each other's
// results.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     request present
//   req_ready     unit can accept a request this cycle
//   req_op        funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//   req_addr      12-bit CSR address
//   req_rs1_idx   rs1 index, or uimm[4:0] for the immediate forms
//   req_rs1_data  rs1 value; ignored for the immediate forms
//   resp_valid    response present
//   resp_ready    consumer accepts the response
//   resp_rdata    CSR value before the op (0 when illegal)
//   resp_illegal  op raised illegal-instruction
//   hw_we         hardware (trap logic) write enable
//   hw_idx        hardware write target index
//   hw_wdata      hardware write data
//   csr_flat      all CSR contents, entry i at [XLEN*i +: XLEN]
// ---------------------------------------------------------------------------
module csr_rmw_unit #(
    parameter int                    XLEN          = 64,
    parameter int                    NUM_CSR       = 4,
    parameter logic [NUM_CSR*12-1:0] CSR_ADDR_LIST = {12'h305, 12'h341, 12'h342, 12'h340},
    localparam int                   IDX_W         = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [11:0]             req_addr,
    input  logic [4:0]              req_rs1_idx,
    input  logic [XLEN-1:0]         req_rs1_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [XLEN-1:0]         resp_rdata,
    output logic                    resp_illegal,
    input  logic                    hw_we,
    input  logic [IDX_W-1:0]        hw_idx,
    input  logic [XLEN-1:0]         hw_wdata,
    output logic [NUM_CSR*XLEN-1:0] csr_flat
);

    // When NUM_CSR is not a power of two, some hw_idx codes name no CSR.
    localparam bit IDX_FULL = (NUM_CSR == (1 << IDX_W));

    // Address decode: returns {hit, index}. The list is scanned from the top
    // down so that, for a duplicated address, the lowest index is the last
    // match assigned and therefore wins.
    function automatic logic [IDX_W:0] decode_addr(input logic [11:0] addr);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_CSR - 1; i >= 0; i--) begin
            if (CSR_ADDR_LIST[12*i +: 12] == addr) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // New CSR value. kind is funct3[1:0]: 01 write, 10 set, 11 clear.
    function automatic logic [XLEN-1:0] apply_op(input logic [1:0]      kind,
                                                 input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] operand);
        case (kind)
            2'b01:   return operand;
            2'b10:   return old | operand;
            2'b11:   return old & ~operand;
            default: return old;
        endcase
    endfunction

    logic [XLEN-1:0]  csr_q [NUM_CSR];

    logic             stall;
    logic             accept;
    logic [IDX_W:0]   dec;
    logic [XLEN-1:0]  operand_in;

    logic             vld_p1;
    logic [1:0]       kind_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             hit_p1;
    logic             ro_p1;
    logic             zero_src_p1;
    logic [XLEN-1:0]  operand_p1;

    logic [XLEN-1:0]  old_val;
    logic [XLEN-1:0]  new_val;
    logic             suppress;
    logic             illegal;
    logic             fire;
    logic             sw_we;
    logic             hw_hit;

    // A held response freezes the whole pipe; S1 can still fill while empty.
    assign stall      = resp_valid && !resp_ready;
    assign req_ready  = !(vld_p1 && stall);
    assign accept     = req_valid && req_ready;
    assign dec        = decode_addr(req_addr);
    assign operand_in = req_op[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_data;

    // ---- S1: request capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (req_ready) begin
            vld_p1 <= req_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            kind_p1     <= req_op[1:0];
            idx_p1      <= dec[IDX_W-1:0];
            hit_p1      <= dec[IDX_W];
            ro_p1       <= (req_addr[11:10] == 2'b11);
            zero_src_p1 <= (req_rs1_idx == 5'd0);
            operand_p1  <= operand_in;
        end
    end

    // ---- S2: read, modify, write, respond ----
    // Set/clear with rs1 (or uimm) of zero are pure reads; a write never is.
    assign suppress = kind_p1[1] && zero_src_p1;
    assign illegal  = (kind_p1 == 2'b00) || !hit_p1 || (ro_p1 && !suppress);
    assign old_val  = csr_q[idx_p1];
    assign new_val  = apply_op(kind_p1, old_val, operand_p1);
    assign fire     = vld_p1 && !stall;
    assign sw_we    = fire && !illegal && !suppress;
    assign hw_hit   = hw_we && (IDX_FULL || (int'(hw_idx) < NUM_CSR));

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else if (!stall) begin
            resp_valid <= vld_p1;
            if (vld_p1) begin
                resp_rdata   <= illegal ? '0 : old_val;
                resp_illegal <= illegal;
            end
        end
    end

    // The software write is assigned after the hardware write so that it
    // takes priority when both target the same CSR on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                csr_q[i] <= '0;
            end
        end else begin
            if (hw_hit) begin
                csr_q[hw_idx] <= hw_wdata;
            end
            if (sw_we) begin
                csr_q[idx_p1] <= new_val;
            end
        end
    end

    for (genvar g = 0; g < NUM_CSR; g++) begin : g_flat
        assign csr_flat[XLEN*g +: XLEN] = csr_q[g];
    end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_rmw_unit
//
// Bench for csr_rmw_unit with the default parameters
// (list index 0..3 = 0x340, 0x342, 0x341, 0x305).
// Directed single-op vector table, hand-written multi-cycle sequences
// (latency, stall, same-edge hw/sw writes, reset in flight), and a random
// phase checked against an order-of-operations reference model.
// ---------------------------------------------------------------------------
module tb_csr_rmw_unit;

    localparam int XLEN    = 64;
    localparam int NUM_CSR = 4;
    localparam int IDX_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_op;
    logic [11:0]             req_addr;
    logic [4:0]              req_rs1_idx;
    logic [XLEN-1:0]         req_rs1_data;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [XLEN-1:0]         resp_rdata;
    logic                    resp_illegal;
    logic                    hw_we;
    logic [IDX_W-1:0]        hw_idx;
    logic [XLEN-1:0]         hw_wdata;
    logic [NUM_CSR*XLEN-1:0] csr_flat;

    csr_rmw_unit #(
        .XLEN         (XLEN),
        .NUM_CSR      (NUM_CSR),
        .CSR_ADDR_LIST({12'h305, 12'h341, 12'h342, 12'h340})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_rs1_idx (req_rs1_idx),
        .req_rs1_data(req_rs1_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_illegal(resp_illegal),
        .hw_we       (hw_we),
        .hw_idx      (hw_idx),
        .hw_wdata    (hw_wdata),
        .csr_flat    (csr_flat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference address map: entry i of the packed list, lowest bits first.
    logic [11:0] model_addr [NUM_CSR] = '{12'h340, 12'h342, 12'h341, 12'h305};
    logic [XLEN-1:0] mcsr [NUM_CSR];

    typedef struct {
        logic [2:0]      op;
        logic [11:0]     addr;
        logic [4:0]      rs1;
        logic [XLEN-1:0] data;
    } req_t;

    req_t pend[$];

    typedef struct {
        logic [2:0]      op;
        logic [11:0]     addr;
        logic [4:0]      rs1;
        logic [XLEN-1:0] data;
        int              pre_idx;   // -1: no preload, no CSR check
        logic [XLEN-1:0] pre;
        logic [XLEN-1:0] exp_rd;
        logic            exp_ill;
        logic [XLEN-1:0] exp_csr;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] get_csr(input int i);
        return csr_flat[i*XLEN +: XLEN];
    endfunction

    function automatic int lookup(input logic [11:0] addr);
        for (int i = 0; i < NUM_CSR; i++) begin
            if (model_addr[i] == addr) return i;
        end
        return -1;
    endfunction

    // Zicsr semantics in plain terms.
    function automatic void rule(input logic [2:0] op, input int idx, input logic [11:0] addr,
                                 input logic [4:0] rs1, input logic [XLEN-1:0] src,
                                 input logic [XLEN-1:0] old, output logic ill,
                                 output logic [XLEN-1:0] rdata, output logic wr,
                                 output logic [XLEN-1:0] nv);
        logic [XLEN-1:0] operand;
        logic writes;
        logic valid_op;
        operand  = op[2] ? XLEN'(rs1) : src;
        valid_op = 1'b1;
        case (op)
            3'b001, 3'b101: begin writes = 1'b1;        nv = operand;        end
            3'b010, 3'b110: begin writes = (rs1 != 0);  nv = old | operand;  end
            3'b011, 3'b111: begin writes = (rs1 != 0);  nv = old & ~operand; end
            default:        begin writes = 1'b0;        nv = old; valid_op = 1'b0; end
        endcase
        ill   = !valid_op || (idx < 0) || ((addr[11:10] == 2'b11) && writes);
        wr    = writes && !ill;
        rdata = ill ? '0 : old;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        hw_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_CSR; i++) mcsr[i] = '0;
        pend.delete();
    endtask

    task automatic hw_write(input int idx, input logic [XLEN-1:0] d);
        @(negedge clk);
        hw_we = 1'b1;
        hw_idx = IDX_W'(idx);
        hw_wdata = d;
        @(negedge clk);
        hw_we = 1'b0;
    endtask

    task automatic issue_wait(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] rs1,
                              input logic [XLEN-1:0] d, input string name,
                              output logic [XLEN-1:0] rd, output logic il);
        bit got;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_rs1_idx = rs1;
        req_rs1_data = d;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        rd = '0;
        il = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            if (resp_valid) begin
                rd = resp_rdata;
                il = resp_illegal;
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no response expected one", name);
        end
    endtask

    task automatic run_random(input int ncyc);
        bit prev_stall;
        bit p_hw;
        int p_idx;
        logic [XLEN-1:0] p_data;
        logic [XLEN-1:0] held;
        logic [NUM_CSR*XLEN-1:0] mf;
        req_t r;
        int idx;
        logic ill, wr, have;
        logic [XLEN-1:0] rd, nv, old;
        int sel;
        prev_stall = 1'b0;
        p_hw = 1'b0;
        p_idx = 0;
        p_data = '0;
        held = '0;
        for (int c = 0; c < ncyc + 30; c++) begin
            @(negedge clk);
            have = 1'b0;
            idx = -1;
            ill = 1'b0;
            wr = 1'b0;
            rd = '0;
            nv = '0;
            if (prev_stall) begin
                chk("rnd_hold_valid", XLEN'(resp_valid), XLEN'(1));
                chk("rnd_hold_rdata", resp_rdata, held);
            end
            if (resp_valid && !prev_stall) begin
                if (pend.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd_spurious: got response rdata %h expected none", resp_rdata);
                end else begin
                    r = pend.pop_front();
                    idx = lookup(r.addr);
                    old = (idx >= 0) ? mcsr[idx] : '0;
                    rule(r.op, idx, r.addr, r.rs1, r.data, old, ill, rd, wr, nv);
                    have = 1'b1;
                end
            end
            if (p_hw) mcsr[p_idx] = p_data;
            if (have && wr) mcsr[idx] = nv;
            if (have) begin
                chk($sformatf("rnd_rdata_c%0d", c), resp_rdata, rd);
                chk($sformatf("rnd_illegal_c%0d", c), XLEN'(resp_illegal), XLEN'(ill));
            end
            for (int i = 0; i < NUM_CSR; i++) mf[i*XLEN +: XLEN] = mcsr[i];
            n_tests++;
            if (csr_flat !== mf) begin
                n_fail++;
                $display("FAIL rnd_csr_c%0d: got %h expected %h", c, csr_flat, mf);
            end
            held = resp_rdata;
            // drive next cycle
            if (c < ncyc) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_op = 3'($urandom_range(0, 7));
                sel = $urandom_range(0, 5);
                req_addr = (sel < 4) ? model_addr[sel] : (sel == 4) ? 12'hC00 : 12'($urandom);
                req_rs1_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                req_rs1_data = {$urandom, $urandom};
                resp_ready = ($urandom_range(0, 9) < 7);
                hw_we = ($urandom_range(0, 4) == 0);
                hw_idx = IDX_W'($urandom_range(0, NUM_CSR - 1));
                hw_wdata = {$urandom, $urandom};
            end else begin
                req_valid = 1'b0;
                resp_ready = 1'b1;
                hw_we = 1'b0;
            end
            #1;
            if (req_valid && req_ready) begin
                r.op = req_op;
                r.addr = req_addr;
                r.rs1 = req_rs1_idx;
                r.data = req_rs1_data;
                pend.push_back(r);
            end
            prev_stall = resp_valid && !resp_ready;
            p_hw = hw_we;
            p_idx = int'(hw_idx);
            p_data = hw_wdata;
        end
        chk("rnd_drained", XLEN'(pend.size()), XLEN'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] rd;
        logic il;
        logic [XLEN-1:0] got_q[$];
        int issue;

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 3'b000;
        req_addr = '0;
        req_rs1_idx = '0;
        req_rs1_data = '0;
        resp_ready = 1'b1;
        hw_we = 1'b0;
        hw_idx = '0;
        hw_wdata = '0;

        vecs[0]  = '{3'b001, 12'h305, 5'd5,  64'hDEAD, 3,  64'h0,    64'h0,    1'b0, 64'hDEAD};
        vecs[1]  = '{3'b010, 12'h341, 5'd0,  64'hFF,   2,  64'h10,   64'h10,   1'b0, 64'h10};
        vecs[2]  = '{3'b111, 12'h342, 5'd3,  64'h0,    1,  64'hF,    64'hF,    1'b0, 64'hC};
        vecs[3]  = '{3'b101, 12'h342, 5'd0,  64'h123,  1,  64'hC,    64'hC,    1'b0, 64'h0};
        vecs[4]  = '{3'b001, 12'hC00, 5'd1,  64'h5,    -1, 64'h0,    64'h0,    1'b1, 64'h0};
        vecs[5]  = '{3'b010, 12'hC00, 5'd0,  64'h5,    -1, 64'h0,    64'h0,    1'b1, 64'h0};
        vecs[6]  = '{3'b011, 12'h340, 5'd7,  64'hF0,   0,  64'hFF,   64'hFF,   1'b0, 64'h0F};
        vecs[7]  = '{3'b110, 12'h340, 5'd31, 64'h0,    0,  64'h100,  64'h100,  1'b0, 64'h11F};
        vecs[8]  = '{3'b000, 12'h305, 5'd1,  64'h1,    3,  64'h1234, 64'h0,    1'b1, 64'h1234};
        vecs[9]  = '{3'b100, 12'h305, 5'd1,  64'h1,    3,  64'h1234, 64'h0,    1'b1, 64'h1234};
        vecs[10] = '{3'b001, 12'h305, 5'd0,  64'h0,    3,  64'h77,   64'h77,   1'b0, 64'h0};
        vecs[11] = '{3'b111, 12'h341, 5'd0,  64'hFFFF, 2,  64'h55,   64'h55,   1'b0, 64'h55};
        vecs[12] = '{3'b010, 12'h341, 5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[13] = '{3'b011, 12'h999, 5'd1,  64'h1,    -1, 64'h0,    64'h0,    1'b1, 64'h0};
        vecs[14] = '{3'b101, 12'h341, 5'h15, 64'hFFFF, 2,  64'h3,    64'h3,    1'b0, 64'h15};

        // Reset state
        do_reset();
        chk("rst_req_ready", XLEN'(req_ready), XLEN'(1));
        chk("rst_resp_valid", XLEN'(resp_valid), XLEN'(0));
        chk("rst_resp_rdata", resp_rdata, '0);
        chk("rst_resp_illegal", XLEN'(resp_illegal), XLEN'(0));
        for (int i = 0; i < NUM_CSR; i++) chk($sformatf("rst_csr%0d", i), get_csr(i), '0);

        // Latency: present in cycle c, response visible in cycle c+2
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'b001;
        req_addr = 12'h305;
        req_rs1_idx = 5'd5;
        req_rs1_data = 64'hDEAD;
        resp_ready = 1'b1;
        #1;
        chk("lat_req_ready", XLEN'(req_ready), XLEN'(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_c1_valid", XLEN'(resp_valid), XLEN'(0));
        @(negedge clk);
        chk("lat_c2_valid", XLEN'(resp_valid), XLEN'(1));
        chk("lat_c2_rdata", resp_rdata, '0);
        chk("lat_c2_csr", get_csr(3), 64'hDEAD);
        @(negedge clk);
        chk("lat_c3_valid", XLEN'(resp_valid), XLEN'(0));

        // Directed vector table
        do_reset();
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].pre_idx >= 0) hw_write(vecs[v].pre_idx, vecs[v].pre);
            issue_wait(vecs[v].op, vecs[v].addr, vecs[v].rs1, vecs[v].data,
                       $sformatf("vec%0d", v), rd, il);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_illegal", v), XLEN'(il), XLEN'(vecs[v].exp_ill));
            if (vecs[v].pre_idx >= 0) begin
                @(negedge clk);
                chk($sformatf("vec%0d_csr", v), get_csr(vecs[v].pre_idx), vecs[v].exp_csr);
            end
        end

        // Four back-to-back RSI to 0x340 with a 3-cycle consumer stall
        do_reset();
        issue = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            req_valid = (issue < 4);
            req_op = 3'b110;
            req_addr = 12'h340;
            req_rs1_idx = 5'(1 << issue);
            req_rs1_data = 64'hFFFF;
            resp_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (resp_valid && resp_ready) got_q.push_back(resp_rdata);
            if (req_valid && req_ready) issue++;
        end
        req_valid = 1'b0;
        chk("b2b_count", XLEN'(got_q.size()), XLEN'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_rdata%0d", i),
                (i < got_q.size()) ? got_q[i] : 64'hBAD, XLEN'((1 << i) - 1));
        end
        chk("b2b_csr", get_csr(0), 64'hF);

        // Same-edge hw write and S2 software write
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h305; req_rs1_idx = 5'd1;
        req_rs1_data = 64'h5555; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; hw_we = 1'b1; hw_idx = 2'd3; hw_wdata = 64'hAAAA;
        @(negedge clk);
        hw_we = 1'b0;
        chk("same_csr_sw_wins", get_csr(3), 64'h5555);
        chk("same_csr_rdata", resp_rdata, 64'h0);

        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h305; req_rs1_idx = 5'd1;
        req_rs1_data = 64'h1111;
        @(negedge clk);
        req_valid = 1'b0; hw_we = 1'b1; hw_idx = 2'd0; hw_wdata = 64'hBBBB;
        @(negedge clk);
        hw_we = 1'b0;
        chk("diff_csr_sw", get_csr(3), 64'h1111);
        chk("diff_csr_hw", get_csr(0), 64'hBBBB);

        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b010; req_addr = 12'h305; req_rs1_idx = 5'd0;
        req_rs1_data = 64'hFFFF;
        @(negedge clk);
        req_valid = 1'b0; hw_we = 1'b1; hw_idx = 2'd3; hw_wdata = 64'hCCCC;
        @(negedge clk);
        hw_we = 1'b0;
        chk("suppr_hw_applies", get_csr(3), 64'hCCCC);
        chk("suppr_rdata", resp_rdata, 64'h1111);

        // Reset with ops in flight
        hw_write(2, 64'h99);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h341; req_rs1_idx = 5'd1;
        req_rs1_data = 64'h7;
        @(negedge clk);
        req_addr = 12'h342; req_rs1_data = 64'h8;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstfl_valid%0d", k), XLEN'(resp_valid), XLEN'(0));
            @(negedge clk);
        end
        chk("rstfl_req_ready", XLEN'(req_ready), XLEN'(1));
        for (int i = 0; i < NUM_CSR; i++) chk($sformatf("rstfl_csr%0d", i), get_csr(i), '0);

        // Random traffic against the reference model
        do_reset();
        run_random(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
